// File: rtl/reaction_game_core.sv
`default_nettype none
// ============================================================================
// Module   : reaction_game_core
// Brief    : Multi-player reaction game. Each button is synchronised,
//            debounced and edge-detected. A round counts down, lights the
//            lamp, and the first (lowest-index) presser scores a point.
//            The first player to reach WIN_SCORE wins the match.
//            Optional macro EARLY_PENALTY_EN: a press during the countdown
//            costs the lowest-index presser one point and aborts the round.
// Revision : 1.0 - initial release
// ============================================================================
module reaction_game_core #(
    parameter int NUM_PLAYERS     = 2,
    parameter int SCORE_W         = 4,
    parameter int WIN_SCORE       = 5,
    parameter int COUNT_TICKS     = 50,
    parameter int TICK_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           clear_scores,
    input  logic [NUM_PLAYERS-1:0]         btn,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic                           lamp,
    output logic [1:0]                     state,
    output logic                           winner_valid,
    output logic [2:0]                     winner_id
);

    localparam int C_CNT_W = $clog2(COUNT_TICKS + 1);
    localparam int C_PRE_W = $clog2(TICK_DIV + 1);
    localparam int C_DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [C_CNT_W-1:0] c_count_init = C_CNT_W'(COUNT_TICKS);
    localparam logic [C_CNT_W-1:0] c_count_one  = C_CNT_W'(1);
    localparam logic [C_PRE_W-1:0] c_pre_last   = C_PRE_W'(TICK_DIV - 1);
    localparam logic [C_DB_W-1:0]  c_db_last    = C_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] c_score_max  = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] c_win        = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_ARMED     = 2'd2,
        ST_WON       = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button input path: 2-flop synchroniser
    // ------------------------------------------------------------------
    logic [NUM_PLAYERS-1:0] r_sync1_q, w_sync1_d;
    logic [NUM_PLAYERS-1:0] r_sync2_q, w_sync2_d;

    // Next values of the synchroniser chain
    always_comb begin
        w_sync1_d = btn;
        w_sync2_d = r_sync1_q;
    end

    // Synchroniser flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1_q <= '0;
            r_sync2_q <= '0;
        end else begin
            r_sync1_q <= w_sync1_d;
            r_sync2_q <= w_sync2_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-player debouncer: the level follows the synchronised input only
    // after DEBOUNCE_CYCLES consecutive samples that differ from it.
    // ------------------------------------------------------------------
    logic [NUM_PLAYERS-1:0] w_deb_level;

    generate
        for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_debounce
            logic [C_DB_W-1:0] r_cnt_q, w_cnt_d;
            logic              r_level_q, w_level_d;

            // Count disagreeing samples; any agreeing sample restarts the count
            always_comb begin
                w_cnt_d   = '0;
                w_level_d = r_level_q;
                if (r_sync2_q[g] != r_level_q) begin
                    if (r_cnt_q == c_db_last) begin
                        w_level_d = r_sync2_q[g];
                    end else begin
                        w_cnt_d = r_cnt_q + C_DB_W'(1);
                    end
                end
            end

            // Debouncer state flops
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt_q   <= '0;
                    r_level_q <= 1'b0;
                end else begin
                    r_cnt_q   <= w_cnt_d;
                    r_level_q <= w_level_d;
                end
            end

            assign w_deb_level[g] = r_level_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Rising-edge detect: one press pulse per debounced press
    // ------------------------------------------------------------------
    logic [NUM_PLAYERS-1:0] r_deb_prev_q, w_deb_prev_d;
    logic [NUM_PLAYERS-1:0] w_press;
    logic [NUM_PLAYERS-1:0] w_sel;
    logic                   w_any;

    // Edge detection and lowest-index selection (x & -x isolates lowest set bit)
    always_comb begin
        w_deb_prev_d = w_deb_level;
        w_press      = w_deb_level & ~r_deb_prev_q;
        w_sel        = w_press & (~w_press + NUM_PLAYERS'(1));
        w_any        = |w_press;
    end

    // Previous debounced level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb_prev_q <= '0;
        end else begin
            r_deb_prev_q <= w_deb_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Game state
    // ------------------------------------------------------------------
    state_t                                r_state_q, w_state_d;
    logic [C_CNT_W-1:0]                    r_count_q, w_count_d;
    logic [C_PRE_W-1:0]                    r_presc_q, w_presc_d;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   r_scores_q, w_scores_d;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   w_inc;
    logic [2:0]                            r_winner_q, w_winner_d;
    logic                                  r_lamp_q, w_lamp_d;
    logic                                  r_wvalid_q, w_wvalid_d;
`ifdef EARLY_PENALTY_EN
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   w_dec;
`endif

    // Saturating +1 (and -1 when the foul rule is built in) for every score
    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            w_inc[i] = (r_scores_q[i] == c_score_max) ? r_scores_q[i]
                                                      : r_scores_q[i] + SCORE_W'(1);
`ifdef EARLY_PENALTY_EN
            w_dec[i] = (r_scores_q[i] == '0) ? r_scores_q[i]
                                             : r_scores_q[i] - SCORE_W'(1);
`endif
        end
    end

    // Round sequencing, scoring and clear handling
    always_comb begin
        w_state_d  = r_state_q;
        w_count_d  = r_count_q;
        w_presc_d  = r_presc_q;
        w_scores_d = r_scores_q;
        w_winner_d = r_winner_q;

        if (clear_scores) begin
            w_state_d  = ST_IDLE;
            w_count_d  = '0;
            w_presc_d  = '0;
            w_scores_d = '0;
            w_winner_d = '0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (start) begin
                        w_count_d = c_count_init;
                        w_presc_d = '0;
                        w_state_d = ST_COUNTDOWN;
                    end
                end
                ST_COUNTDOWN: begin
`ifdef EARLY_PENALTY_EN
                    if (w_any) begin
                        // Jumped the gun: penalise and abandon the round
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (w_sel[i]) begin
                                w_scores_d[i] = w_dec[i];
                            end
                        end
                        w_count_d = '0;
                        w_presc_d = '0;
                        w_state_d = ST_IDLE;
                    end else
`endif
                    begin
                        if (r_presc_q == c_pre_last) begin
                            w_presc_d = '0;
                            w_count_d = r_count_q - c_count_one;
                            if (r_count_q == c_count_one) begin
                                w_state_d = ST_ARMED;
                            end
                        end else begin
                            w_presc_d = r_presc_q + C_PRE_W'(1);
                        end
                    end
                end
                ST_ARMED: begin
                    if (w_any) begin
                        w_state_d = ST_IDLE;
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (w_sel[i]) begin
                                w_scores_d[i] = w_inc[i];
                                if (w_inc[i] == c_win) begin
                                    w_state_d  = ST_WON;
                                    w_winner_d = 3'(i);
                                end
                            end
                        end
                    end
                end
                default: begin
                    // ST_WON holds until clear_scores or reset
                    w_state_d = r_state_q;
                end
            endcase
        end
    end

    // Registered status outputs decoded from the state being entered
    always_comb begin
        w_lamp_d   = (w_state_d == ST_ARMED);
        w_wvalid_d = (w_state_d == ST_WON);
    end

    // Game state flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_count_q  <= '0;
            r_presc_q  <= '0;
            r_scores_q <= '0;
            r_winner_q <= '0;
            r_lamp_q   <= 1'b0;
            r_wvalid_q <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_count_q  <= w_count_d;
            r_presc_q  <= w_presc_d;
            r_scores_q <= w_scores_d;
            r_winner_q <= w_winner_d;
            r_lamp_q   <= w_lamp_d;
            r_wvalid_q <= w_wvalid_d;
        end
    end

    assign scores       = r_scores_q;
    assign lamp         = r_lamp_q;
    assign state        = r_state_q;
    assign winner_valid = r_wvalid_q;
    assign winner_id    = r_winner_q;

endmodule
`default_nettype wire

// File: doc/reaction_game_core.md
REACTION_GAME_CORE -- requirements
Module: reaction_game_core

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of player buttons (legal 2..8).
REQ-002 SHALL have parameter SCORE_W, default 4, width of each player score.
REQ-003 SHALL have parameter WIN_SCORE, default 5, score ending the match (1..2^SCORE_W-1).
REQ-004 SHALL have parameter COUNT_TICKS, default 50, countdown length in ticks (>=1).
REQ-005 SHALL have parameter TICK_DIV, default 50000, clk cycles per countdown tick (>=1).
REQ-006 SHALL have parameter DEBOUNCE_CYCLES, default 50000, stable cycles to accept a button level (>=1).
REQ-007 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port start  input  1  synchronous level, begins a round.
REQ-010 SHALL have port clear_scores  input  1  synchronous, zeroes scores, returns to IDLE.
REQ-011 SHALL have port btn  input  NUM_PLAYERS  raw asynchronous player buttons, active-high.
REQ-012 SHALL have port scores  output  NUM_PLAYERS*SCORE_W  packed scores, player i at [i*SCORE_W +: SCORE_W].
REQ-013 SHALL have port lamp  output  1  high while ARMED.
REQ-014 SHALL have port state  output  2  IDLE=0, COUNTDOWN=1, ARMED=2, WON=3.
REQ-015 SHALL have port winner_valid  output  1  high while WON.
REQ-016 SHALL have port winner_id  output  3  index of match winner, valid with winner_valid.

Function
REQ-017 SHALL pass each btn bit through a 2-flop synchroniser, then a per-player debouncer updating the debounced level only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
REQ-018 SHALL generate a one-cycle press pulse per player on each debounced rising edge; holding a button yields one press.
REQ-019 SHALL, in IDLE with start=1, load countdown=COUNT_TICKS, clear prescaler, enter COUNTDOWN next cycle.
REQ-020 SHALL, in COUNTDOWN, decrement countdown once per TICK_DIV cycles and enter ARMED on the cycle countdown reaches 0.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL, in ARMED, award the press: score+1 for lowest-index pressing player when several press same cycle; others ignored.
REQ-023 SHALL, after an ARMED award, enter WON if new score equals WIN_SCORE (winner_id=that player), else IDLE.
REQ-024 SHALL ignore presses in IDLE and WON; WON persists until clear_scores or reset.
REQ-025 SHALL, on clear_scores=1 in any state, zero all scores, clear winner, enter IDLE next cycle; clear_scores overrides start and presses same cycle.
REQ-026 SHALL never let any score wrap above 2^SCORE_W-1 or below 0.
REQ-027 SHALL drive lamp, winner_valid, state as registered outputs decoded from the current state.

Reset
REQ-028 SHALL on reset=1 asynchronously force state=IDLE, scores=0, lamp=0, winner_valid=0, winner_id=0, countdown=0, prescaler=0, debounced levels=0, synchronisers=0.
REQ-029 SHALL, on reset mid-countdown or mid-debounce, discard in-flight round and presses; operation resumes from IDLE on first clk after release.

Configuration
REQ-030 SHALL, with macro EARLY_PENALTY_EN defined, treat a press in COUNTDOWN as foul: lowest-index presser score-1 saturating at 0, round aborted to IDLE next cycle.
REQ-031 SHALL, without EARLY_PENALTY_EN, ignore presses in COUNTDOWN; countdown continues unaffected.

Verification (NUM_PLAYERS=4, SCORE_W=4, WIN_SCORE=3, COUNT_TICKS=5, TICK_DIV=4, DEBOUNCE_CYCLES=3)
REQ-032 SHALL cover: start pulse in IDLE -> state=1 next cycle, lamp=1 exactly 20 cycles later, state=2.
REQ-033 SHALL cover: btn[2] held 10 cycles while ARMED -> scores[11:8]=1 once, state=0, lamp=0.
REQ-034 SHALL cover: btn[1] and btn[3] rise same cycle while ARMED -> only player 1 incremented.
REQ-035 SHALL cover: player 0 wins three armed rounds -> state=3, winner_valid=1, winner_id=0; later start ignored; clear_scores -> all scores 0, state=0.
REQ-036 SHALL cover: btn[0] during COUNTDOWN with score 1 -> with EARLY_PENALTY_EN score 0 and state=0; without, score 1 and lamp rises on schedule.
REQ-037 SHALL cover: 2-cycle btn glitch -> no press; reset asserted mid-COUNTDOWN -> all outputs 0 immediately, no clk edge needed.
